enc16_4_scan: RTL

ENC16_4_SCAN -- requirements
Module: enc16_4_scan

---
 rtl/enc16_4_scan_if.sv | 28 ++
 rtl/enc16_4_scan.sv | 109 ++++++++++
 2 files changed

// File: rtl/enc16_4_scan_if.sv
// Request/handshake bundle for the 16-to-4 scanning priority encoder.
// The slave side is the encoder; the master side is the requester/consumer.
interface enc16_4_scan_if;
  logic       en;
  logic       load;
  logic       i0, i1, i2, i3, i4, i5, i6, i7;
  logic       i8, i9, i10, i11, i12, i13, i14, i15;
  logic       ready;
  logic       valid;
  logic       a, b, c, d;
  logic       none;
  logic       busy;
  logic [4:0] rem;

  modport slave (
    input  en, load, ready,
    input  i0, i1, i2, i3, i4, i5, i6, i7,
    input  i8, i9, i10, i11, i12, i13, i14, i15,
    output valid, a, b, c, d, none, busy, rem
  );

  modport master (
    output en, load, ready,
    output i0, i1, i2, i3, i4, i5, i6, i7,
    output i8, i9, i10, i11, i12, i13, i14, i15,
    input  valid, a, b, c, d, none, busy, rem
  );
endinterface

// File: rtl/enc16_4_scan.sv
// Captures a 16-bit request vector and hands out its set indices lowest-first,
// one per accepted transfer. Every output comes straight from a register.
module enc16_4_scan (
  input  logic          clk,
  input  logic          rst,
  enc16_4_scan_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_nxt;
  logic [15:0] pend, pend_nxt, pend_clr, req;
  logic [4:0]  rem, rem_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        valid, valid_nxt;
  logic        none, none_nxt;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int k = 0; k < 16; k++) cnt = cnt + {4'd0, v[k]};
    return cnt;
  endfunction

  // Scans downward so the last hit is the lowest set index.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 15; k >= 0; k--) if (v[k]) r = 4'(k);
    return r;
  endfunction

  assign req = {bus.i15, bus.i14, bus.i13, bus.i12, bus.i11, bus.i10, bus.i9, bus.i8,
                bus.i7,  bus.i6,  bus.i5,  bus.i4,  bus.i3,  bus.i2,  bus.i1, bus.i0};

  assign pend_clr = pend & ~(16'd1 << idx);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    rem_nxt   = rem;
    idx_nxt   = idx;
    valid_nxt = valid;
    none_nxt  = 1'b0;
    if (!bus.en) begin
      valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_nxt = 1'b0;
          if (bus.load) begin
            pend_nxt = req;
            rem_nxt  = popcount16(req);
            if (req != 16'd0) begin
              state_nxt = SCAN;
              idx_nxt   = lowest_set(req);
              valid_nxt = 1'b1;
            end else begin
              none_nxt = 1'b1;
            end
          end
        end
        SCAN: begin
          // valid is re-armed here after an en=0 gap without consuming anything.
          valid_nxt = 1'b1;
          if (valid && bus.ready) begin
            pend_nxt = pend_clr;
            rem_nxt  = popcount16(pend_clr);
            if (pend_clr == 16'd0) begin
              state_nxt = IDLE;
              valid_nxt = 1'b0;
            end else begin
              idx_nxt = lowest_set(pend_clr);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 16'd0;
      rem   <= 5'd0;
      idx   <= 4'd0;
      valid <= 1'b0;
      none  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      rem   <= rem_nxt;
      idx   <= idx_nxt;
      valid <= valid_nxt;
      none  <= none_nxt;
    end
  end

  assign bus.valid = valid;
  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.none  = none;
  assign bus.busy  = (state == SCAN);
  assign bus.rem   = rem;

endmodule
